// File: rtl/register_file_pkg.sv
// Shared types and limits for the multi-port register file.
package register_file_pkg;

    localparam int unsigned MAX_READ_PORTS = 4;

    typedef enum logic [0:0] {
        RF_IDLE,
        RF_CLEAR
    } rf_state_e;

endpackage

// File: rtl/register_file_mp_reg.sv
// Single storage entry: loadable register with asynchronous active-high reset.
module register_file_mp_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: one write port, NUM_READ registered read ports, write-first bypass
// and a sequenced bulk clear. Define REGISTER_FILE_MP_ZERO_REG_EN to hardwire entry 0 to zero.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_READ   = 2,
    localparam int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           write_en,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [WIDTH-1:0]               write_data,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*WIDTH-1:0]      read_data,
    input  logic                           clear_req,
    output logic                           busy
);

    if (NUM_READ < 1 || NUM_READ > MAX_READ_PORTS) begin : g_bad_ports
        $error("register_file_mp: NUM_READ out of range");
    end

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;

    logic [WIDTH-1:0]          entry_q [DEPTH];
    logic [WIDTH-1:0]          entry_d;
    logic [DEPTH-1:0]          wr_sel;
    logic                      idle_wr;
    logic                      clr_step;
    logic                      wr_valid;
    logic [ADDR_WIDTH-1:0]     rd_addr [NUM_READ];
    logic [NUM_READ*WIDTH-1:0] rdata_d, rdata_q;

    assign idle_wr  = (state_q == RF_IDLE) && enable && write_en;
    assign clr_step = (state_q == RF_CLEAR) && enable;
    assign entry_d  = (state_q == RF_CLEAR) ? '0 : write_data;
    // Any decoded entry means the write address is in range (and not the hardwired zero entry).
    assign wr_valid = |wr_sel;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
`ifdef REGISTER_FILE_MP_ZERO_REG_EN
        if (i == 0) begin : g_zero
            assign wr_sel[i]  = 1'b0;
            assign entry_q[i] = '0;
        end else begin : g_store
`else
        begin : g_store
`endif
            logic entry_en;
            assign wr_sel[i] = (write_addr == ADDR_WIDTH'(i));
            assign entry_en  = (idle_wr && wr_sel[i]) || (clr_step && idx_q == ADDR_WIDTH'(i));

            register_file_mp_reg #(
                .WIDTH(WIDTH)
            ) u_reg (
                .clk(clk),
                .rst(rst),
                .en (entry_en),
                .d  (entry_d),
                .q  (entry_q[i])
            );
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd_addr
        assign rd_addr[k] = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Out-of-range read addresses match no entry and fall through to zero.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr[k] == ADDR_WIDTH'(i)) begin
                    rdata_d[k*WIDTH +: WIDTH] = entry_q[i];
                end
            end
            if (idle_wr && wr_valid && write_addr == rd_addr[k]) begin
                rdata_d[k*WIDTH +: WIDTH] = write_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            RF_IDLE: begin
                if (enable && clear_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            RF_CLEAR: begin
                if (enable) begin
                    if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d = RF_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = RF_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (enable) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign read_data = rdata_q;
    assign busy      = (state_q == RF_CLEAR);

endmodule
